// File: rtl/rr_arb16_idx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb16_idx_if : request/release/grant bundle for rr_arb16_idx           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rr_arb16_idx_if;
   logic [15:0] req;
   logic        rel;
   logic        gnt_vld;
   logic [3:0]  gnt_idx;
   logic [3:0]  ptr;
   logic        timeout;

   modport master (
      output req, rel,
      input  gnt_vld, gnt_idx, ptr, timeout
   );

   modport slave (
      input  req, rel,
      output gnt_vld, gnt_idx, ptr, timeout
   );
endinterface
`default_nettype wire

// File: rtl/rr_arb16_idx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb16_idx : 16-way round-robin arbiter, registered grant index        |
// | Optional hold watchdog enabled by macro RR_ARB_TIMEOUT_EN. Rev 1.0       |
// +--------------------------------------------------------------------------+
module rr_arb16_idx #(
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   rr_arb16_idx_if.slave    bus
);

   localparam logic [0:0] c_st_idle  = 1'b0;
   localparam logic [0:0] c_st_grant = 1'b1;

   generate
      if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_chk
         $error("rr_arb16_idx: TIMEOUT out of range 2..65535");
      end
   endgenerate

   logic [0:0]  r_state;
   logic [3:0]  r_gnt_idx;
   logic [3:0]  r_ptr;

   logic        w_gnt;
   logic        w_hold_req;
   logic        w_forced;
   logic        w_release;
   logic [3:0]  w_base;
   logic [15:0] w_mask;
   logic [15:0] w_cand_req;
   logic        w_found;
   logic [3:0]  w_win;
   logic [3:0]  w_pos;

   assign w_gnt      = (r_state == c_st_grant);
   assign w_hold_req = bus.req[r_gnt_idx];

`ifdef RR_ARB_TIMEOUT_EN
   localparam logic [15:0] c_to_last = 16'(TIMEOUT - 1);

   logic [15:0] r_cnt;
   logic        r_timeout;
   logic        w_new_grant;

   // Forced release only when nothing else is already releasing the grant.
   assign w_forced    = w_gnt && !bus.rel && w_hold_req && (r_cnt == c_to_last);
   assign w_new_grant = w_found && (!w_gnt || w_release);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= 16'd0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_forced;
         if (w_new_grant) begin
            r_cnt <= 16'd0;
         end else if (w_gnt) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign bus.timeout = r_timeout;
`else
   assign w_forced    = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   assign w_release = w_gnt && (bus.rel || !w_hold_req || w_forced);

   // On release the search restarts just past the holder, which is masked out.
   assign w_base     = w_release ? (r_gnt_idx + 4'd1) : r_ptr;
   assign w_mask     = w_gnt ? ~(16'h0001 << r_gnt_idx) : 16'hffff;
   assign w_cand_req = bus.req & w_mask;

   always_comb begin
      w_found = 1'b0;
      w_win   = 4'd0;
      w_pos   = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         w_pos = w_base + 4'(i);
         if (w_cand_req[w_pos]) begin
            w_found = 1'b1;
            w_win   = w_pos;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_st_idle;
         r_gnt_idx <= 4'd0;
         r_ptr     <= 4'd0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_found) begin
                  r_state   <= c_st_grant;
                  r_gnt_idx <= w_win;
               end
            end
            default: begin
               if (w_release) begin
                  r_ptr <= w_base;
                  if (w_found) begin
                     r_gnt_idx <= w_win;
                  end else begin
                     r_state <= c_st_idle;
                  end
               end
            end
         endcase
      end
   end

   assign bus.gnt_vld = w_gnt;
   assign bus.gnt_idx = r_gnt_idx;
   assign bus.ptr     = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb16_idx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_arb16_idx : directed bench with cycle model for rr_arb16_idx       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rr_arb16_idx;

   localparam int TO = 4;

   logic clk;
   logic rst;
   rr_arb16_idx_if bus ();

   rr_arb16_idx #(.TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: arbitration stated directly as "first requester at or after start".
   function automatic int pick(input logic [15:0] r, input int start);
      for (int k = 0; k < 16; k++) begin
         if (r[(start + k) % 16]) return (start + k) % 16;
      end
      return -1;
   endfunction

   bit m_vld;
   int m_idx;
   int m_ptr;
   int m_cnt;
   bit m_to;
   int mw;
   int mnp;
   bit m_forced;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld <= 1'b0;
         m_idx <= 0;
         m_ptr <= 0;
         m_cnt <= 0;
         m_to  <= 1'b0;
      end else begin
         m_to <= 1'b0;
         if (!m_vld) begin
            mw = pick(bus.req, m_ptr);
            if (mw >= 0) begin
               m_vld <= 1'b1;
               m_idx <= mw;
               m_cnt <= 0;
            end
         end else begin
            m_forced = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            m_forced = !bus.rel && bus.req[m_idx] && (m_cnt == TO - 1);
`endif
            if (bus.rel || !bus.req[m_idx] || m_forced) begin
               mnp = (m_idx + 1) % 16;
               m_ptr <= mnp;
               m_to  <= m_forced;
               mw = pick(bus.req & ~(16'h0001 << m_idx), mnp);
               if (mw >= 0) begin
                  m_idx <= mw;
                  m_cnt <= 0;
               end else begin
                  m_vld <= 1'b0;
               end
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_vld", int'(bus.gnt_vld), int'(m_vld));
         check("model_idx", int'(bus.gnt_idx), m_idx);
         check("model_ptr", int'(bus.ptr), m_ptr);
         check("model_timeout", int'(bus.timeout), int'(m_to));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   int alt_idx [4] = '{15, 0, 15, 0};
   int alt_ptr [4] = '{1, 0, 1, 0};
   int exp_idx;
   int exp_to;

   initial begin
      rst     = 1'b1;
      bus.req = 16'h0000;
      bus.rel = 1'b0;
      repeat (2) tick();
      rst    = 1'b0;
      cmp_en = 1'b1;

      repeat (5) tick();
      check("reset_vld", int'(bus.gnt_vld), 0);
      check("reset_idx", int'(bus.gnt_idx), 0);
      check("reset_ptr", int'(bus.ptr), 0);
      check("reset_timeout", int'(bus.timeout), 0);

      // rel with no grant active must do nothing
      bus.rel = 1'b1;
      tick();
      bus.rel = 1'b0;
      check("idle_rel_ptr", int'(bus.ptr), 0);
      check("idle_rel_vld", int'(bus.gnt_vld), 0);

      bus.req = 16'h8001;
      tick();
      check("alt_first_idx", int'(bus.gnt_idx), 0);
      check("alt_first_vld", int'(bus.gnt_vld), 1);
      bus.rel = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("alt_idx", int'(bus.gnt_idx), alt_idx[k]);
         check("alt_ptr", int'(bus.ptr), alt_ptr[k]);
         check("alt_vld", int'(bus.gnt_vld), 1);
      end
      bus.rel = 1'b0;
      bus.req = 16'h0000;
      tick();
      check("alt_end_vld", int'(bus.gnt_vld), 0);
      check("alt_end_ptr", int'(bus.ptr), 1);

      bus.req = 16'h0010;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("hold4_idx", int'(bus.gnt_idx), 4);
`ifndef RR_ARB_TIMEOUT_EN
         check("hold4_vld", int'(bus.gnt_vld), 1);
`endif
      end
      bus.req = 16'h0000;
      tick();
      check("hold4_drop_vld", int'(bus.gnt_vld), 0);
      check("hold4_drop_ptr", int'(bus.ptr), 5);
      check("hold4_drop_idx", int'(bus.gnt_idx), 4);

      bus.req = 16'h8000;
      tick();
      check("sole15_idx", int'(bus.gnt_idx), 15);
      check("sole15_vld", int'(bus.gnt_vld), 1);
      tick();
      bus.rel = 1'b1;
      tick();
      bus.rel = 1'b0;
      check("sole15_rel_vld", int'(bus.gnt_vld), 0);
      check("sole15_rel_ptr", int'(bus.ptr), 0);
      tick();
      check("sole15_again_vld", int'(bus.gnt_vld), 1);
      check("sole15_again_idx", int'(bus.gnt_idx), 15);

      bus.req = 16'h0080;
      tick();
      check("g7_idx", int'(bus.gnt_idx), 7);
      check("g7_vld", int'(bus.gnt_vld), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_vld", int'(bus.gnt_vld), 0);
      check("async_rst_idx", int'(bus.gnt_idx), 0);
      check("async_rst_ptr", int'(bus.ptr), 0);
      tick();
      rst     = 1'b0;
      bus.req = 16'h0000;
      tick();

      bus.req = 16'h0006;
      for (int k = 1; k <= 12; k++) begin
         tick();
`ifdef RR_ARB_TIMEOUT_EN
         exp_idx = (((k - 1) / TO) % 2 == 0) ? 1 : 2;
         exp_to  = (k > 1 && ((k - 1) % TO) == 0) ? 1 : 0;
`else
         exp_idx = 1;
         exp_to  = 0;
`endif
         check("wdog_idx", int'(bus.gnt_idx), exp_idx);
         check("wdog_timeout", int'(bus.timeout), exp_to);
         check("wdog_vld", int'(bus.gnt_vld), 1);
      end
      bus.req = 16'h0000;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_arb16_idx.md
# rr_arb16_idx

Sixteen-requester round-robin arbiter with grant hold and release handshake. It produces a registered 4-bit grant index plus a valid flag. The index drives the 4-to-16 one-hot decoder directly downstream, which turns it into per-lane select/enable lines. Fairness comes from a rotating priority pointer. An optional watchdog forcibly revokes a grant that is held too long.

## Interface
- `TIMEOUT`, default 64: maximum cycles a grant may be held before forced release. Legal range 2..65535. Used only when `RR_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 16: request vector; bit i is requester i. Level-sensitive.
- `rel` in 1: release pulse from the current grant holder. Ignored while `gnt_vld`=0.
- `gnt_vld` out 1: a grant is active; qualifies `gnt_idx`.
- `gnt_idx` out 4: index of the granted requester, fed to the decoder input.
- `ptr` out 4: current priority pointer, the first index searched. Debug/visibility only.
- `timeout` out 1: one-cycle pulse on a forced release. Tied 0 without `RR_ARB_TIMEOUT_EN`.

## Operation
- Two states: IDLE (`gnt_vld`=0) and GRANT (`gnt_vld`=1).
- Search order: starting at `ptr`, then `ptr+1`, … `ptr+15`, all mod 16. The first set `req` bit wins.
- IDLE with any `req` bit set: register the winner into `gnt_idx`, set `gnt_vld`, go to GRANT.
- IDLE with `req`=0: stay in IDLE. `gnt_idx` holds its last value.
- GRANT, release event: `rel`=1, or `req[gnt_idx]`=0 (requester withdrew), or watchdog expiry.
  - On release, set `ptr` ← `gnt_idx`+1, wrapping 15→0.
  - Search again from the new `ptr` in the same cycle, using the current `req` with bit `gnt_idx` masked.
  - Winner found: `gnt_idx` updates and `gnt_vld` stays 1 (back-to-back grant, no bubble).
  - No winner: `gnt_vld`←0, go to IDLE.
- The released requester is masked for exactly one decision only. If it is still the sole requester on the next IDLE cycle, it is granted again.
- GRANT with no release event: `gnt_idx`, `gnt_vld` and `ptr` are all held. New requests from other requesters do not preempt.
- `ptr` changes only on a release.
- `gnt_idx` never changes while `gnt_vld`=1 except at a release.
- Reset values: state IDLE, `gnt_vld`=0, `gnt_idx`=0, `ptr`=0, `timeout`=0, watchdog count=0.
- Reset asserted mid-grant clears all state immediately, asynchronously. The grant is lost and `ptr` returns to 0.

## Timing
- All outputs are registered; no combinational path from input to output.
- Request-to-grant latency is 1 cycle: `req` sampled at edge N gives `gnt_vld`/`gnt_idx` valid after edge N.
- Release-to-next-grant latency is 1 cycle: `rel` sampled at edge M gives the new `gnt_idx`, or `gnt_vld`=0, after edge M.
- Minimum grant length is 1 cycle: `rel` may be asserted in the first cycle `gnt_vld`=1.
- Simultaneous `rel` and `req[gnt_idx]` fall count as a single release; `ptr` advances once.
- `rel` while `gnt_vld`=0 has no effect.
- Worst-case wait for a continuously requesting line is 15 grants.

## Configuration
- Macro: `RR_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on every new grant and increments each cycle in GRANT.
  - When the count equals `TIMEOUT`-1 and no other release event is present, a forced release happens at that edge, exactly like `rel`.
  - `timeout` pulses high for the following cycle.
- Not defined:
  - No counter is instantiated.
  - `timeout` is constant 0.
  - A grant is held indefinitely until `rel` or request withdrawal.

## Test plan
- Reset, then `req`=16'h0000 for 5 cycles: `gnt_vld`=0, `gnt_idx`=0, `ptr`=0, `timeout`=0 throughout.
- `req`=16'h8001 held, with `rel` pulsed each cycle a grant is active:
  - grants alternate 0, 15, 0, 15;
  - `ptr` reads 1, 0, 1, 0 after each release;
  - `gnt_vld` never drops (no bubble).
- `req`=16'h0010, no `rel` for 10 cycles, then `req`=16'h0000: `gnt_idx`=4 held for the whole request, `gnt_vld` falls 1 cycle after the withdrawal, `ptr`=5.
- Grant held on index 15 with `req`=16'h8000, then `rel` with `req`=16'h8000: next cycle `gnt_vld`=0 and `ptr`=0; the cycle after, index 15 is granted again.
- `rst` pulsed asynchronously mid-grant on index 7: `gnt_vld`=0, `gnt_idx`=0 and `ptr`=0 immediately, without waiting for a clock edge.
- With `RR_ARB_TIMEOUT_EN` and `TIMEOUT`=4, `req`=16'h0006, no `rel`:
  - index 1 is granted for 4 cycles, then index 2;
  - `timeout` pulses once at each handover;
  - without the macro, index 1 is held indefinitely.
